// File: rtl/vram_beat_bridge_if.sv
// Signal bundle between the vector requester, the beat bridge and the 64-bit data RAM.
// The slave modport is the bridge's view; the master modport is the requester-plus-memory side.
interface vram_beat_bridge_if;
    logic         vreq_valid;
    logic         vreq_ready;
    logic         vreq_we;
    logic [63:0]  vreq_addr;
    logic [511:0] vreq_wdata;
    logic [511:0] vreq_wmask;
    logic         vresp_valid;
    logic [511:0] vresp_rdata;
    logic         mem_ren;
    logic [63:0]  mem_ridx;
    logic [63:0]  mem_rdata;
    logic         mem_wen;
    logic [63:0]  mem_widx;
    logic [63:0]  mem_wdata;
    logic [63:0]  mem_wmask;

    modport slave (
        input  vreq_valid, vreq_we, vreq_addr, vreq_wdata, vreq_wmask, mem_rdata,
        output vreq_ready, vresp_valid, vresp_rdata,
               mem_ren, mem_ridx, mem_wen, mem_widx, mem_wdata, mem_wmask
    );

    modport master (
        output vreq_valid, vreq_we, vreq_addr, vreq_wdata, vreq_wmask, mem_rdata,
        input  vreq_ready, vresp_valid, vresp_rdata,
               mem_ren, mem_ridx, mem_wen, mem_widx, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/vram_beat_bridge.sv
// Serialises one 512-bit vector read/write into eight 64-bit RAM beats and
// reassembles read beats into a single 512-bit response.
module vram_beat_bridge #(
    parameter logic [63:0] PC_START       = 64'h0000_0000_8000_0000,
    parameter bit          SKIP_ZERO_MASK = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset,
    vram_beat_bridge_if.slave    bus
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_RESP
    } state_t;

    state_t         r_state;
    logic [3:0]     r_cnt;
    logic [63:0]    r_base;
    logic [511:0]   r_wdata;
    logic [511:0]   r_wmask;
    logic [511:0]   r_rdata;
    logic           r_vresp_valid;
    logic           r_mem_ren;
    logic [63:0]    r_mem_ridx;
    logic           r_mem_wen;
    logic [63:0]    r_mem_widx;
    logic [63:0]    r_mem_wdata;
    logic [63:0]    r_mem_wmask;

    logic [63:0]    w_wdata_beat [8];
    logic [63:0]    w_wmask_beat [8];
    logic [7:0]     w_beat_en;
    logic [63:0]    w_addr_off;
    logic [63:0]    w_req_base;
    logic           w_first_en;
    logic [3:0]     w_next_cnt;
    logic [2:0]     w_next_beat;
    logic [2:0]     w_cap_slot;
    logic [63:0]    w_next_idx;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_beat
            assign w_wdata_beat[gi] = r_wdata[64*gi +: 64];
            assign w_wmask_beat[gi] = r_wmask[64*gi +: 64];
            assign w_beat_en[gi]    = !SKIP_ZERO_MASK || (|r_wmask[64*gi +: 64]);
        end
    endgenerate

    // Low address bits are dropped by the shift; misaligned requests are a caller error.
    assign w_addr_off  = bus.vreq_addr - PC_START;
    assign w_req_base  = w_addr_off >> 3;
    assign w_first_en  = !SKIP_ZERO_MASK || (|bus.vreq_wmask[63:0]);
    assign w_next_cnt  = r_cnt + 4'd1;
    assign w_next_beat = r_cnt[2:0] + 3'd1;
    assign w_next_idx  = r_base + 64'(w_next_cnt);
    // READ cycle c (c >= 1) sees the data for the beat issued in cycle c-1.
    assign w_cap_slot  = r_cnt[2:0] - 3'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 4'd0;
            r_base        <= 64'd0;
            r_wdata       <= 512'd0;
            r_wmask       <= 512'd0;
            r_rdata       <= 512'd0;
            r_vresp_valid <= 1'b0;
            r_mem_ren     <= 1'b0;
            r_mem_ridx    <= 64'd0;
            r_mem_wen     <= 1'b0;
            r_mem_widx    <= 64'd0;
            r_mem_wdata   <= 64'd0;
            r_mem_wmask   <= 64'd0;
        end else begin
            r_vresp_valid <= 1'b0;
            r_mem_ren     <= 1'b0;
            r_mem_ridx    <= 64'd0;
            r_mem_wen     <= 1'b0;
            r_mem_widx    <= 64'd0;
            r_mem_wdata   <= 64'd0;
            r_mem_wmask   <= 64'd0;

            unique case (r_state)
                ST_IDLE: begin
                    if (bus.vreq_valid) begin
                        r_base  <= w_req_base;
                        r_wdata <= bus.vreq_wdata;
                        r_wmask <= bus.vreq_wmask;
                        r_cnt   <= 4'd0;
                        // Beat 0 goes out in the cycle right after acceptance.
                        if (bus.vreq_we) begin
                            r_state     <= ST_WRITE;
                            r_mem_wen   <= w_first_en;
                            r_mem_widx  <= w_req_base;
                            r_mem_wdata <= bus.vreq_wdata[63:0];
                            r_mem_wmask <= bus.vreq_wmask[63:0];
                        end else begin
                            r_state    <= ST_READ;
                            r_mem_ren  <= 1'b1;
                            r_mem_ridx <= w_req_base;
                        end
                    end
                end

                ST_WRITE: begin
                    if (r_cnt == 4'd7) begin
                        r_state       <= ST_RESP;
                        r_cnt         <= 4'd0;
                        r_vresp_valid <= 1'b1;
                    end else begin
                        r_cnt       <= w_next_cnt;
                        r_mem_wen   <= w_beat_en[w_next_beat];
                        r_mem_widx  <= w_next_idx;
                        r_mem_wdata <= w_wdata_beat[w_next_beat];
                        r_mem_wmask <= w_wmask_beat[w_next_beat];
                    end
                end

                ST_READ: begin
                    if (r_cnt != 4'd0) begin
                        r_rdata[{w_cap_slot, 6'b0} +: 64] <= bus.mem_rdata;
                    end
                    if (r_cnt < 4'd7) begin
                        r_mem_ren  <= 1'b1;
                        r_mem_ridx <= w_next_idx;
                    end
                    if (r_cnt == 4'd8) begin
                        r_state       <= ST_RESP;
                        r_cnt         <= 4'd0;
                        r_vresp_valid <= 1'b1;
                    end else begin
                        r_cnt <= w_next_cnt;
                    end
                end

                ST_RESP: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= 4'd0;
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    assign bus.vreq_ready  = (r_state == ST_IDLE) && !reset;
    assign bus.vresp_valid = r_vresp_valid;
    assign bus.vresp_rdata = r_rdata;
    assign bus.mem_ren     = r_mem_ren;
    assign bus.mem_ridx    = r_mem_ridx;
    assign bus.mem_wen     = r_mem_wen;
    assign bus.mem_widx    = r_mem_widx;
    assign bus.mem_wdata   = r_mem_wdata;
    assign bus.mem_wmask   = r_mem_wmask;
endmodule

// File: tb/tb_vram_beat_bridge.sv
// Directed bench for vram_beat_bridge: beat timing, sparse masks, read assembly,
// back-to-back acceptance, response hold and reset abort.
module tb_vram_beat_bridge;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vram_beat_bridge_if bus();

    vram_beat_bridge dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    // Memory model: returns index*3 one cycle after a read enable.
    always @(posedge clk) begin
        bus.mem_rdata <= bus.mem_ren ? bus.mem_ridx * 64'd3 : 64'd0;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ren"},   bus.mem_ren,   1'b0);
        check({tag, "_wen"},   bus.mem_wen,   1'b0);
        check({tag, "_ridx"},  bus.mem_ridx,  64'd0);
        check({tag, "_widx"},  bus.mem_widx,  64'd0);
        check({tag, "_wdata"}, bus.mem_wdata, 64'd0);
        check({tag, "_wmask"}, bus.mem_wmask, 64'd0);
        check({tag, "_vresp"}, bus.vresp_valid, 1'b0);
    endtask

    task automatic run_write(input logic [63:0] addr, input logic [511:0] wd,
                             input logic [511:0] wm, input logic [63:0] base,
                             input logic [7:0] exp_en, input string name);
        @(negedge clk);
        check({name, "_ready_before"}, bus.vreq_ready, 1'b1);
        bus.vreq_valid = 1'b1;
        bus.vreq_we    = 1'b1;
        bus.vreq_addr  = addr;
        bus.vreq_wdata = wd;
        bus.vreq_wmask = wm;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            bus.vreq_valid = 1'b0;
            check($sformatf("%s_wen%0d", name, k), bus.mem_wen, exp_en[k]);
            if (exp_en[k]) begin
                check($sformatf("%s_widx%0d", name, k), bus.mem_widx, base + 64'(k));
                check($sformatf("%s_wdata%0d", name, k), bus.mem_wdata, wd[64*k +: 64]);
                check($sformatf("%s_wmask%0d", name, k), bus.mem_wmask, wm[64*k +: 64]);
            end
            check($sformatf("%s_ren%0d", name, k), bus.mem_ren, 1'b0);
            check($sformatf("%s_ready%0d", name, k), bus.vreq_ready, 1'b0);
            check($sformatf("%s_vresp%0d", name, k), bus.vresp_valid, 1'b0);
        end
        @(negedge clk);
        check({name, "_vresp_t9"}, bus.vresp_valid, 1'b1);
        check({name, "_wen_t9"},   bus.mem_wen,     1'b0);
        check({name, "_ready_t9"}, bus.vreq_ready,  1'b0);
        @(negedge clk);
        check({name, "_vresp_t10"}, bus.vresp_valid, 1'b0);
        check({name, "_ready_t10"}, bus.vreq_ready,  1'b1);
        $display("txn %s: write addr=%h base=%0d beat_en=%b", name, addr, base, exp_en);
    endtask

    task automatic run_read(input logic [63:0] addr, input logic [63:0] base,
                            input string name, output logic [511:0] exp);
        for (int k = 0; k < 8; k++) exp[64*k +: 64] = (base + 64'(k)) * 64'd3;
        @(negedge clk);
        check({name, "_ready_before"}, bus.vreq_ready, 1'b1);
        bus.vreq_valid = 1'b1;
        bus.vreq_we    = 1'b0;
        bus.vreq_addr  = addr;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            bus.vreq_valid = 1'b0;
            check($sformatf("%s_ren%0d", name, k),  bus.mem_ren,  1'b1);
            check($sformatf("%s_ridx%0d", name, k), bus.mem_ridx, base + 64'(k));
            check($sformatf("%s_wen%0d", name, k),  bus.mem_wen,  1'b0);
            check($sformatf("%s_vresp%0d", name, k), bus.vresp_valid, 1'b0);
        end
        @(negedge clk);
        check({name, "_ren_t9"},   bus.mem_ren,     1'b0);
        check({name, "_vresp_t9"}, bus.vresp_valid, 1'b0);
        check({name, "_ready_t9"}, bus.vreq_ready,  1'b0);
        @(negedge clk);
        check({name, "_vresp_t10"}, bus.vresp_valid, 1'b1);
        check({name, "_rdata_t10"}, bus.vresp_rdata, exp);
        check({name, "_ready_t10"}, bus.vreq_ready,  1'b0);
        @(negedge clk);
        check({name, "_vresp_t11"}, bus.vresp_valid, 1'b0);
        check({name, "_ready_t11"}, bus.vreq_ready,  1'b1);
        $display("txn %s: read addr=%h base=%0d", name, addr, base);
    endtask

    initial begin
        logic [511:0] wd;
        logic [511:0] wm;
        logic [511:0] rd_exp;
        logic [511:0] rd_exp2;

        bus.vreq_valid = 1'b0;
        bus.vreq_we    = 1'b0;
        bus.vreq_addr  = 64'd0;
        bus.vreq_wdata = 512'd0;
        bus.vreq_wmask = 512'd0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready_in_reset", bus.vreq_ready, 1'b0);
        check_idle_outputs("rst");
        check("rst_rdata", bus.vresp_rdata, 512'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready_after", bus.vreq_ready, 1'b1);
        $display("txn reset: released");

        // Full write, addr 0x8000_0040 -> indices 8..15
        for (int k = 0; k < 8; k++) wd[64*k +: 64] = 64'h1111_1111_1111_1111 * 64'(k + 1);
        wm = '1;
        run_write(64'h0000_0000_8000_0040, wd, wm, 64'd8, 8'hFF, "full_wr");

        // Sparse write: slices 2 and 5 zero, slice 0 lower half only
        for (int k = 0; k < 8; k++) begin
            wd[64*k +: 64] = 64'hA5A5_0000_0000_0000 + 64'(k);
            wm[64*k +: 64] = 64'hFFFF_FFFF_FFFF_FFFF;
        end
        wm[63:0]    = 64'h0000_0000_FFFF_FFFF;
        wm[191:128] = 64'd0;
        wm[383:320] = 64'd0;
        run_write(64'h0000_0000_8000_0100, wd, wm, 64'h20, 8'hDB, "sparse_wr");

        // Read-back from index 8: slot k = (8+k)*3
        run_read(64'h0000_0000_8000_0040, 64'd8, "read8", rd_exp);

        // Write after read must leave the assembled read data untouched
        for (int k = 0; k < 8; k++) wd[64*k +: 64] = 64'hDEAD_0000_0000_0000 | 64'(k);
        wm = '1;
        run_write(64'h0000_0000_8000_0200, wd, wm, 64'h40, 8'hFF, "hold_wr");
        check("hold_rdata", bus.vresp_rdata, rd_exp);

        // Back-to-back: valid held high across a read followed by a write
        for (int k = 0; k < 8; k++) rd_exp2[64*k +: 64] = (64'd16 + 64'(k)) * 64'd3;
        @(negedge clk);
        bus.vreq_valid = 1'b1;
        bus.vreq_we    = 1'b0;
        bus.vreq_addr  = 64'h0000_0000_8000_0080;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            check($sformatf("b2b_ready_c%0d", c), bus.vreq_ready, 1'b0);
            check($sformatf("b2b_wen_c%0d", c),   bus.mem_wen,    1'b0);
            if (c == 1) begin
                bus.vreq_we    = 1'b1;
                bus.vreq_addr  = 64'h0000_0000_8000_0000;
                bus.vreq_wdata = wd;
                bus.vreq_wmask = '1;
            end
            if (c == 10) begin
                check("b2b_vresp_t10", bus.vresp_valid, 1'b1);
                check("b2b_rdata_t10", bus.vresp_rdata, rd_exp2);
            end
        end
        @(negedge clk);
        check("b2b_ready_t11", bus.vreq_ready, 1'b1);
        @(negedge clk);
        bus.vreq_valid = 1'b0;
        check("b2b_wr_wen0",  bus.mem_wen,  1'b1);
        check("b2b_wr_widx0", bus.mem_widx, 64'd0);
        check("b2b_wr_ready", bus.vreq_ready, 1'b0);
        repeat (7) @(negedge clk);
        check("b2b_wr_widx7", bus.mem_widx, 64'd7);
        @(negedge clk);
        check("b2b_wr_vresp", bus.vresp_valid, 1'b1);
        check("b2b_hold_rdata", bus.vresp_rdata, rd_exp2);
        @(negedge clk);
        check("b2b_ready_end", bus.vreq_ready, 1'b1);
        $display("txn b2b: read base=16 then write base=0");

        // Reset during beat 3 of a write
        @(negedge clk);
        bus.vreq_valid = 1'b1;
        bus.vreq_we    = 1'b1;
        bus.vreq_addr  = 64'h0000_0000_8000_0040;
        bus.vreq_wmask = '1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.vreq_valid = 1'b0;
            check($sformatf("rstmid_wen%0d", k),  bus.mem_wen,  1'b1);
            check($sformatf("rstmid_widx%0d", k), bus.mem_widx, 64'd8 + 64'(k));
        end
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_wen_in_reset",   bus.mem_wen,     1'b0);
        check("rstmid_ready_in_reset", bus.vreq_ready,  1'b0);
        check("rstmid_vresp_in_reset", bus.vresp_valid, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("rstmid_after");
        check("rstmid_rdata_after", bus.vresp_rdata, 512'd0);
        check("rstmid_ready_after", bus.vreq_ready, 1'b1);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check($sformatf("rstmid_quiet_wen%0d", c),   bus.mem_wen,     1'b0);
            check($sformatf("rstmid_quiet_vresp%0d", c), bus.vresp_valid, 1'b0);
        end
        $display("txn reset_mid_write: aborted after beat 3");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/vram_beat_bridge.md
# vram_beat_bridge

Memory-side responder for the vector unit's 512-bit memory port. Accepts one 512-bit vector read or write request at a time and serialises it into eight 64-bit beats on a 64-bit indexed RAM port with the same signal set as the scalar data RAM (`ren`/`rIdx`/`rdata`/`wIdx`/`wdata`/`wmask`/`wen`). For reads, it reassembles the eight returned beats into one 512-bit response. It sits between the vector core and the shared 64-bit data memory, so vector traffic no longer needs a dedicated wide RAM model.

## Interface
Parameters:
- `PC_START`, default 64'h0000_0000_8000_0000: base byte address subtracted before index computation.
- `SKIP_ZERO_MASK`, default 1: when 1, a write beat whose 64-bit mask slice is all zero drives `mem_wen`=0 for that beat.

Ports:
- `clock`  in  1  single clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `vreq_valid`  in  1  request present; held until accepted.
- `vreq_ready`  out  1  bridge can accept a request.
- `vreq_we`  in  1  1 = write, 0 = read.
- `vreq_addr`  in  64  byte address; bits [2:0] must be 0.
- `vreq_wdata`  in  512  write data; beat k = bits [64k+63:64k].
- `vreq_wmask`  in  512  bit-level write mask; same beat slicing.
- `vresp_valid`  out  1  one-cycle completion pulse, for both reads and writes.
- `vresp_rdata`  out  512  assembled read data.
- `mem_ren`  out  1  beat read enable.
- `mem_ridx`  out  64  beat read index.
- `mem_rdata`  in  64  beat read data, valid the cycle after `mem_ren`.
- `mem_wen`  out  1  beat write enable.
- `mem_widx`  out  64  beat write index.
- `mem_wdata`  out  64  beat write data.
- `mem_wmask`  out  64  beat write mask.

## Operation
- **States:**
  - IDLE: `vreq_ready`=1.
  - WRITE: 8 cycles.
  - READ: 9 cycles, pipelined issue/capture.
  - RESP: 1 cycle.
- **Acceptance.**
  - A request is accepted on the edge where `vreq_valid`&`vreq_ready`.
  - On acceptance, `vreq_we`, the base index, `vreq_wdata` and `vreq_wmask` are latched.
  - The base index is (`vreq_addr` − `PC_START`) >> 3, as 64-bit unsigned arithmetic with natural wrap.
- **Beat index.** Beat k uses index base+k, k = 0..7, 64-bit wrap.
- **WRITE.**
  - One beat per cycle, k ascending.
  - `mem_wen`=1 with `mem_widx`=base+k, `mem_wdata`/`mem_wmask` = slice k.
  - If `SKIP_ZERO_MASK`=1 and slice k of the mask is 0, `mem_wen`=0 but the cycle is still consumed; timing is identical for every mask.
  - After beat 7, go to RESP.
- **READ.**
  - Issue counter: `mem_ren`=1 with `mem_ridx`=base+k on READ cycles 1..8.
  - Capture: `mem_rdata` is stored into slot k one cycle after the issue of beat k (READ cycles 2..9).
  - After capture 7, go to RESP.
- **RESP.**
  - `vresp_valid`=1 for exactly one cycle, then return to IDLE.
  - There is no backpressure on the response; the requester must consume it in that cycle.
- **`vresp_rdata`.**
  - Updated only by completed reads; slots are written as beats arrive.
  - Holds its value through writes and idle periods until the next read overwrites it.
- **Idle outputs.** Outside active beats, `mem_ren`=`mem_wen`=0 and `mem_ridx`/`mem_widx`/`mem_wdata`/`mem_wmask` are 0.
- **Busy requests.** `vreq_valid` while busy is ignored: `vreq_ready`=0 in all non-IDLE states.
- **Reset.** `vreq_ready` = (state==IDLE) & !`reset`.
- **Reset mid-operation.**
  - Aborts immediately: state goes to IDLE and counters clear.
  - No `vresp_valid` is produced for the aborted request.
  - Beats already written remain in memory; no further beats are issued after the reset edge.
- **Misaligned address.** `vreq_addr`[2:0]≠0 is a usage error; the low bits are discarded by the >>3.

## Timing
- **Reset values:** all outputs 0, including `vresp_rdata`=0; state IDLE; counters 0.
- **Write latency,** acceptance edge at cycle T:
  - Beats in cycles T+1..T+8.
  - `vresp_valid` in T+9.
  - `vreq_ready`=1 again in T+10.
- **Read latency,** acceptance edge at cycle T:
  - `mem_ren` in T+1..T+8.
  - Captures at the end of T+2..T+9.
  - `vresp_valid` with full data in T+10.
  - `vreq_ready` in T+11.
- **Throughput:** one request per 10 (write) or 11 (read) cycles, back-to-back.
- **Drive type:** all `mem_*` outputs are registered-state driven, with no combinational path from `vreq_*` to `mem_*`.

## Test plan
- **Full write:** addr 0x8000_0040, mask all-ones, wdata beat k = 0x1111_1111_1111_1111×(k+1).
  - Response: `mem_wen`=1 on 8 consecutive cycles, `mem_widx` 8..15, `vresp_valid` at T+9.
- **Sparse write:** `SKIP_ZERO_MASK`=1, mask slices 2 and 5 zero, slice 0 = 0x0000_0000_FFFF_FFFF.
  - Response: `mem_wen` low in beats 2 and 5; beat 0 `mem_wmask`=0x0000_0000_FFFF_FFFF; response still at T+9.
- **Read-back:** memory model returns index×3 one cycle after `mem_ren`; read addr 0x8000_0040.
  - Response: `vresp_rdata` slot k = (8+k)×3 at T+10.
- **Back-to-back:** `vreq_valid` held high for read then write.
  - Response: second acceptance exactly at T+11; ready low for the whole first transaction; busy-time `vreq_valid` is not accepted.
- **Reset mid-write:** reset asserted during beat 3.
  - Response: beats 0..3 issued, none after; no `vresp_valid`; all outputs 0 and `vreq_ready`=1 the cycle after reset deasserts.
- **Hold:** a write after a read.
  - Response: `vresp_rdata` keeps the read value.
